// File: rtl/dm_selfcheck_engine.sv
// dm_selfcheck_engine
//   Self-checking harness for data-memory bring-up: preloads memory from a
//   vector stream, pulses the processor reset, waits (bounded) for done, then
//   streams expected values and compares them against memory contents.
// Ports
//   clk, reset (async, active low), start (pulse)
//   vec_valid/vec_ready/vec_addr/vec_data/vec_last : vector stream in
//   mem_we/mem_re/mem_addr/mem_wdata/mem_rdata      : data-memory debug port
//   dut_reset (active high), dut_done               : processor control
//   busy, finished, pass, timeout, err_count, first_err_addr : results
module dm_selfcheck_engine #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int CNTW       = 8,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            vec_valid,
  output logic            vec_ready,
  input  logic [AW-1:0]   vec_addr,
  input  logic [DW-1:0]   vec_data,
  input  logic            vec_last,
  output logic            mem_we,
  output logic            mem_re,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            dut_reset,
  input  logic            dut_done,
  output logic            busy,
  output logic            finished,
  output logic            pass,
  output logic            timeout,
  output logic [CNTW-1:0] err_count,
  output logic [AW-1:0]   first_err_addr
);

  // Shared phase counter: RESET_DUT length, WAIT_DONE timeout, DRAIN length.
  localparam int CW = $clog2(TIMEOUT + RST_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RST, S_WAIT, S_CHECK, S_DRAIN, S_REPORT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  // Expected value travels alongside the read: exp1 with mem_re, exp2 with rdata.
  logic [DW-1:0]   exp1_q, exp1_d, exp2_q, exp2_d;
  logic            cmp_vld_q, cmp_vld_d;
  logic [AW-1:0]   cmp_addr_q, cmp_addr_d;
  logic [CNTW-1:0] err_q, err_d;
  logic [AW-1:0]   ferr_q, ferr_d;
  logic            timeout_q, timeout_d;
  logic            dut_reset_q, dut_reset_d;
  logic            busy_q, busy_d, finished_q, finished_d, pass_q, pass_d;
  logic            hs;

  assign vec_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign hs        = vec_valid && vec_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    exp1_d      = exp1_q;
    exp2_d      = exp1_q;
    cmp_vld_d   = mem_re_q;
    cmp_addr_d  = mem_addr_q;
    err_d       = err_q;
    ferr_d      = ferr_q;
    timeout_d   = timeout_q;

    // Compare stage: rdata is valid the cycle after mem_re.
    if (cmp_vld_q && (mem_rdata != exp2_q)) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (err_q == '0) ferr_d = cmp_addr_q;
    end

    case (state_q)
      S_IDLE, S_REPORT: begin
        if (start) begin
          state_d   = S_LOAD;
          err_d     = '0;
          ferr_d    = '0;
          timeout_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = vec_addr;
          mem_wdata_d = vec_data;
          if (vec_last) begin
            state_d = S_RST;
            cnt_d   = '0;
          end
        end
      end
      S_RST: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // done ignored on the first cycle to mask a stale flag; done beats timeout
        if ((cnt_q != '0) && dut_done) begin
          state_d = S_CHECK;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = S_REPORT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (hs) begin
          mem_re_d   = 1'b1;
          mem_addr_d = vec_addr;
          exp1_d     = vec_data;
          if (vec_last) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        // two cycles covers the read and compare stages of the last vector
        if (cnt_q == CW'(1)) state_d = S_REPORT;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = !((state_d == S_IDLE) || (state_d == S_REPORT));
    finished_d  = (state_d == S_REPORT);
    dut_reset_d = (state_d == S_IDLE) || (state_d == S_RST);
    pass_d      = finished_d && (err_d == '0) && !timeout_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      exp1_q      <= '0;
      exp2_q      <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_addr_q  <= '0;
      err_q       <= '0;
      ferr_q      <= '0;
      timeout_q   <= 1'b0;
      dut_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      exp1_q      <= exp1_d;
      exp2_q      <= exp2_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_addr_q  <= cmp_addr_d;
      err_q       <= err_d;
      ferr_q      <= ferr_d;
      timeout_q   <= timeout_d;
      dut_reset_q <= dut_reset_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      pass_q      <= pass_d;
    end
  end

  assign mem_we         = mem_we_q;
  assign mem_re         = mem_re_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign dut_reset      = dut_reset_q;
  assign busy           = busy_q;
  assign finished       = finished_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_dm_selfcheck_engine.sv
// Directed bench for dm_selfcheck_engine with a small memory + XOR/AND
// processor model. CNTW=2 and TIMEOUT=16 so saturation and timeout are reachable.
module tb_dm_selfcheck_engine;
  logic       clk = 1'b0;
  logic       reset, start, vec_valid, vec_last;
  logic [7:0] vec_addr, vec_data;
  logic       vec_ready, mem_we, mem_re, dut_reset, busy, finished, pass, timeout;
  logic [7:0] mem_addr, mem_wdata, first_err_addr;
  logic [7:0] mem_rdata;
  logic       dut_done;
  logic [1:0] err_count;
  logic       prog_en;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  int         pcnt;
  int         we_cnt = 0;
  int         re_cnt = 0;

  dm_selfcheck_engine #(.AW(8), .DW(8), .CNTW(2), .RST_CYCLES(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_addr(vec_addr),
    .vec_data(vec_data), .vec_last(vec_last),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dut_reset(dut_reset), .dut_done(dut_done),
    .busy(busy), .finished(finished), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  // Memory + processor model: after reset release, wait 6 cycles, then
  // mem[2]=mem[0]^mem[1], mem[5]=mem[3]&mem[4], raise done.
  always @(posedge clk) begin
    if (mem_we) begin mem[mem_addr] <= mem_wdata; we_cnt <= we_cnt + 1; end
    if (mem_re) begin mem_rdata <= mem[mem_addr]; re_cnt <= re_cnt + 1; end
    if (!reset || dut_reset) begin
      pcnt     <= 0;
      dut_done <= 1'b0;
    end else if (prog_en && !dut_done) begin
      pcnt <= pcnt + 1;
      if (pcnt == 5) begin
        mem[2]   <= mem[0] ^ mem[1];
        mem[5]   <= mem[3] & mem[4];
        dut_done <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] d, input logic l, input bit gap);
    int k = 0;
    if (gap) @(negedge clk);
    @(negedge clk);
    vec_valid = 1'b1; vec_addr = a; vec_data = d; vec_last = l;
    while (!vec_ready && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) check("send_ready_wait", 32'(k), 32'd0);
    @(posedge clk);
    #1 vec_valid = 1'b0; vec_last = 1'b0;
  endtask

  task automatic wait_finished();
    int k = 0;
    while (!finished && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) check("finish_wait", 32'(k), 32'd0);
  endtask

  task automatic load_xor(input bit with_aa);
    send(8'h00, 8'hF0, 1'b0, 1'b0);
    send(8'h01, 8'hCC, 1'b0, 1'b0);
    send(8'h03, 8'hC3, 1'b0, 1'b0);
    if (with_aa) send(8'h06, 8'hAA, 1'b0, 1'b0);
    send(8'h04, 8'h55, 1'b1, 1'b0);
  endtask

  int we0, re0, n, hs_n, k;

  initial begin
    reset = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
    vec_addr = '0; vec_data = '0; prog_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dut_reset", 32'(dut_reset), 1);
    check("rst_busy",      32'(busy), 0);
    check("rst_finished",  32'(finished), 0);
    check("rst_pass",      32'(pass), 0);
    check("rst_err",       32'(err_count), 0);
    check("rst_we",        32'(mem_we), 0);
    check("rst_ready",     32'(vec_ready), 0);
    @(negedge clk); reset = 1'b1;

    // Run A: XOR/AND pass, start pulsed during WAIT_DONE is ignored
    we0 = we_cnt;
    pulse_start();
    check("a_busy_load", 32'(busy), 1);
    check("a_dut_reset_load", 32'(dut_reset), 0);
    load_xor(1'b0);
    k = 0;
    while (!dut_reset && k < 50) begin @(negedge clk); k++; end
    check("a_rst_seen", 32'(dut_reset), 1);
    while (dut_reset && k < 50) begin @(negedge clk); k++; end
    check("a_rst_released", 32'(dut_reset), 0);
    pulse_start();
    check("a_start_ignored_busy", 32'(busy), 1);
    check("a_start_ignored_dut_reset", 32'(dut_reset), 0);
    send(8'h02, 8'h3C, 1'b0, 1'b0);
    send(8'h05, 8'h41, 1'b1, 1'b0);
    wait_finished();
    check("a_pass",    32'(pass), 1);
    check("a_err",     32'(err_count), 0);
    check("a_timeout", 32'(timeout), 0);
    check("a_busy",    32'(busy), 0);
    check("a_we_cnt",  32'(we_cnt - we0), 4);
    check("a_mem0",    32'(mem[0]), 32'hF0);
    check("a_mem4",    32'(mem[4]), 32'h55);

    // Run B: two mismatches, first at addr 5
    pulse_start();
    load_xor(1'b1);
    send(8'h02, 8'h3C, 1'b0, 1'b0);
    send(8'h05, 8'hFF, 1'b0, 1'b0);
    send(8'h06, 8'h00, 1'b1, 1'b0);
    wait_finished();
    check("b_err",   32'(err_count), 2);
    check("b_first", 32'(first_err_addr), 5);
    check("b_pass",  32'(pass), 0);
    repeat (3) @(negedge clk);
    check("b_hold_err", 32'(err_count), 2);

    // Run C: start in REPORT clears results; 5 mismatches with bubbles saturate
    pulse_start();
    check("c_clear_err",      32'(err_count), 0);
    check("c_clear_first",    32'(first_err_addr), 0);
    check("c_clear_finished", 32'(finished), 0);
    load_xor(1'b0);
    re0 = re_cnt;
    send(8'h00, 8'h00, 1'b0, 1'b1);
    send(8'h01, 8'h00, 1'b0, 1'b1);
    send(8'h03, 8'h00, 1'b0, 1'b1);
    send(8'h04, 8'h00, 1'b0, 1'b1);
    send(8'h02, 8'h00, 1'b1, 1'b1);
    wait_finished();
    repeat (2) @(negedge clk);
    check("c_err_sat", 32'(err_count), 3);
    check("c_first",   32'(first_err_addr), 0);
    check("c_re_cnt",  32'(re_cnt - re0), 5);
    check("c_pass",    32'(pass), 0);

    // Run D: done never raised -> timeout 16 cycles after RESET_DUT exits
    prog_en = 1'b0;
    pulse_start();
    send(8'h07, 8'h11, 1'b1, 1'b0);
    @(negedge clk);
    vec_valid = 1'b1; vec_addr = 8'h07; vec_data = 8'h11; vec_last = 1'b0;
    hs_n = 0; k = 0;
    while (dut_reset && k < 50) begin
      if (vec_ready) hs_n++;
      @(negedge clk); k++;
    end
    check("d_rst_released", 32'(dut_reset), 0);
    n = 0;
    while (!timeout && n < 100) begin
      if (vec_ready) hs_n++;
      @(negedge clk); n++;
    end
    vec_valid = 1'b0;
    check("d_timeout_cycles", 32'(n), 16);
    check("d_timeout",  32'(timeout), 1);
    check("d_finished", 32'(finished), 1);
    check("d_pass",     32'(pass), 0);
    check("d_no_check", 32'(hs_n), 0);
    prog_en = 1'b1;

    // Run E: reset mid-CHECK aborts, then a clean rerun passes
    pulse_start();
    load_xor(1'b0);
    send(8'h02, 8'h3C, 1'b0, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("e_abort_dut_reset", 32'(dut_reset), 1);
    check("e_abort_busy",      32'(busy), 0);
    check("e_abort_finished",  32'(finished), 0);
    check("e_abort_ready",     32'(vec_ready), 0);
    @(negedge clk); reset = 1'b1;
    pulse_start();
    load_xor(1'b0);
    send(8'h02, 8'h3C, 1'b0, 1'b0);
    send(8'h05, 8'h41, 1'b1, 1'b0);
    wait_finished();
    check("e_pass",    32'(pass), 1);
    check("e_err",     32'(err_count), 0);
    check("e_timeout", 32'(timeout), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_selfcheck_engine.md
# dm_selfcheck_engine

Synthesizable self-checking harness that generalises the data-memory preload / run / compare flow used for milestone bring-up. It streams preload vectors into data memory, pulses the processor reset, waits for `done` with a bounded timeout, then streams expected-value vectors and compares them against memory contents. It sits between a vector source (bench, ROM or host link) and the processor's data-memory debug port, beside `top_level`.

## Interface
- `AW`, 8: data-memory address width.
- `DW`, 8: data-memory word width.
- `CNTW`, 8: error-counter width; the counter saturates.
- `RST_CYCLES`, 2: cycles `dut_reset` is held high in RESET_DUT, ≥1.
- `TIMEOUT`, 4096: maximum WAIT_DONE cycles before abort, ≥1.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a run from IDLE or REPORT.
- `vec_valid` in 1: vector present.
- `vec_ready` out 1: engine accepts the vector this cycle.
- `vec_addr` in AW: vector address.
- `vec_data` in DW: preload value or expected value.
- `vec_last` in 1: final vector of the current phase.
- `mem_we` out 1: data-memory write strobe.
- `mem_re` out 1: data-memory read strobe.
- `mem_addr` out AW: data-memory address.
- `mem_wdata` out DW: write data.
- `mem_rdata` in DW: read data, valid one cycle after `mem_re`.
- `dut_reset` out 1: active-high processor reset.
- `dut_done` in 1: processor completion flag.
- `busy` out 1: high whenever the state is not IDLE or REPORT.
- `finished` out 1: high in REPORT.
- `pass` out 1: `finished` & `err_count==0` & `!timeout`.
- `timeout` out 1: the run was aborted in WAIT_DONE.
- `err_count` out CNTW: number of mismatches.
- `first_err_addr` out AW: address of the first mismatch.

## Operation
- States: IDLE, LOAD, RESET_DUT, WAIT_DONE, CHECK, DRAIN, REPORT.
- Reset values: `dut_reset`=1. All other outputs are 0. State is IDLE. Asserting reset mid-run aborts to IDLE immediately, with no partial report.
- IDLE/REPORT + `start`: clear `err_count`, `first_err_addr`, `timeout`, `finished` → LOAD. `start` is ignored in every other state.
- LOAD: `vec_ready`=1. Each handshake issues a registered write (`mem_we`, `mem_addr`, `mem_wdata`) in the following cycle. A handshake with `vec_last` → RESET_DUT.
- RESET_DUT: `dut_reset`=1 for exactly RST_CYCLES cycles, `vec_ready`=0 → WAIT_DONE. `dut_reset` is 0 in all states except IDLE and RESET_DUT.
- WAIT_DONE: a counter increments every cycle.
  - `dut_done` sampled high → CHECK. `dut_done` is not sampled in the first WAIT_DONE cycle, so a stale `done` is masked.
  - Counter reaches TIMEOUT-1 without `done` → `timeout`=1, REPORT.
  - `done` and the terminal count in the same cycle: `done` wins.
- CHECK: `vec_ready`=1, fully pipelined at one vector per cycle.
  - A handshake at cycle t drives `mem_re`/`mem_addr` at t+1. `mem_rdata` is compared with the stored expected value at t+2. `err_count` and `first_err_addr` update at t+3.
  - A handshake with `vec_last` → DRAIN.
- DRAIN: `vec_ready`=0. Waits until the compare pipeline is empty (2 cycles) → REPORT.
- `err_count` saturates at 2^CNTW-1. `first_err_addr` is written only when `err_count` was 0 before the increment.
- REPORT: holds all results stable until `start`.

## Timing
- Preload: one write per accepted vector. Write latency is 1 cycle. Back-to-back vectors give back-to-back writes.
- Minimum run time: N_load + RST_CYCLES + 2 + N_check + 3 cycles from `start`.
- `vec_valid` low stalls the pipeline without losing state. A bubble produces no `mem_re` and no compare.
- A vector with `vec_valid` and `vec_ready` but not `vec_last` never changes state.
- All outputs are registered. `vec_ready` is combinational from state only.

## Test plan
- XOR/AND program: preload {0:F0, 1:CC, 3:C3, 4:55} (last on 4). The DUT model writes 3C to addr 2 and 41 to addr 5, then raises `done`. Check {2:3C, 5:41} → `pass`=1, `err_count`=0.
- Same run with expected {2:3C, 5:FF, 6:00} and mem[6]=AA → `err_count`=2, `first_err_addr`=5, `pass`=0.
- `done` is never raised, TIMEOUT=16 → `timeout`=1 exactly 16 cycles after RESET_DUT exits. No CHECK vectors are accepted. `pass`=0.
- CNTW=2 with 5 mismatching check vectors, streamed with `vec_valid` toggling every other cycle → `err_count`=3 (saturated). Verify `mem_re` count is 5 with no extra reads.
- Assert `reset` low mid-CHECK → IDLE next edge, `dut_reset`=1, `busy`=0. A new `start` runs cleanly to `pass`=1.
- `start` pulsed during WAIT_DONE is ignored. `start` in REPORT clears `err_count` and restarts the run.
